fp_core_arbiter: RTL and testbench

FP_CORE_ARBITER -- requirements
Module: fp_core_arbiter

---
 rtl/fp_arb_pkg.sv | 6 +
 rtl/fp_arb_slot.sv | 29 ++
 rtl/fp_core_arbiter.sv | 119 +++++++++++
 tb/tb_fp_core_arbiter.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/fp_arb_pkg.sv
// fp_arb_pkg: shared FSM state type, default width and quiet-NaN constant for the FP core arbiter
package fp_arb_pkg;
    localparam int DEF_DATA_W = 32;
    localparam logic [31:0] QNAN = 32'h7FC00000;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RETURN} state_t;
endpackage

// File: rtl/fp_arb_slot.sv
// fp_arb_slot: per-requester operand capture register with pending flag
module fp_arb_slot import fp_arb_pkg::*; #(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              clr,
    input  logic [DATA_W-1:0] dataa,
    input  logic [DATA_W-1:0] datab,
    output logic              pending,
    output logic [DATA_W-1:0] a,
    output logic [DATA_W-1:0] b
);
    // a start while pending is dropped, so queued operands can never be overwritten
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending <= 1'b0;
            a       <= '0;
            b       <= '0;
        end else if (start && !pending) begin
            pending <= 1'b1;
            a       <= dataa;
            b       <= datab;
        end else if (clr) begin
            pending <= 1'b0;
        end
    end
endmodule

// File: rtl/fp_core_arbiter.sv
// fp_core_arbiter: round-robin sharing of one two-input FP core between two requesters
// Optional WAIT watchdog compiled in with FP_ARB_TIMEOUT_EN.
module fp_core_arbiter import fp_arb_pkg::*; #(
    parameter int DATA_W         = DEF_DATA_W,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req0_start,
    input  logic [DATA_W-1:0] req0_dataa,
    input  logic [DATA_W-1:0] req0_datab,
    input  logic              req1_start,
    input  logic [DATA_W-1:0] req1_dataa,
    input  logic [DATA_W-1:0] req1_datab,
    output logic              req0_done,
    output logic [DATA_W-1:0] req0_result,
    output logic              req0_busy,
    output logic              req1_done,
    output logic [DATA_W-1:0] req1_result,
    output logic              req1_busy,
    output logic              core_start,
    output logic [DATA_W-1:0] core_dataa,
    output logic [DATA_W-1:0] core_datab,
    input  logic              core_done,
    input  logic [DATA_W-1:0] core_result,
    output logic              grant_id,
    output logic              timeout_err
);
    logic [1:0] pend;
    logic [DATA_W-1:0] s0a, s0b, s1a, s1b, val;
    state_t state, nxt;
    logic gnt, nxt_gnt, last, fin, to;

    fp_arb_slot #(.DATA_W(DATA_W)) u_slot0 (
        .clk(clk), .reset_n(reset_n), .start(req0_start), .clr(fin && !gnt),
        .dataa(req0_dataa), .datab(req0_datab), .pending(pend[0]), .a(s0a), .b(s0b)
    );
    fp_arb_slot #(.DATA_W(DATA_W)) u_slot1 (
        .clk(clk), .reset_n(reset_n), .start(req1_start), .clr(fin && gnt),
        .dataa(req1_dataa), .datab(req1_datab), .pending(pend[1]), .a(s1a), .b(s1b)
    );

    assign fin         = state == WAIT && (core_done || to);
    assign val         = to ? DATA_W'(QNAN) : core_result;
    assign core_start  = state == ISSUE;
    assign req0_done   = state == RETURN && !gnt;
    assign req1_done   = state == RETURN && gnt;
    assign req0_busy   = pend[0];
    assign req1_busy   = pend[1];
    assign grant_id    = gnt;

    always_comb begin
        nxt     = state;
        nxt_gnt = gnt;
        case (state)
            IDLE:    if (|pend) begin
                         nxt     = ISSUE;
                         nxt_gnt = &pend ? !last : pend[1];
                     end
            ISSUE:   nxt = WAIT;
            WAIT:    nxt = fin ? RETURN : WAIT;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            gnt   <= 1'b0;
        end else begin
            state <= nxt;
            gnt   <= nxt_gnt;
        end
    end

    // last_grant resets to 1 so requester 0 wins the first tie
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last        <= 1'b1;
            core_dataa  <= '0;
            core_datab  <= '0;
            req0_result <= '0;
            req1_result <= '0;
        end else begin
            if (state == IDLE && nxt == ISSUE) begin
                core_dataa <= nxt_gnt ? s1a : s0a;
                core_datab <= nxt_gnt ? s1b : s0b;
            end
            if (fin) begin
                last <= gnt;
                if (gnt) req1_result <= val;
                else     req0_result <= val;
            end
        end
    end

`ifdef FP_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt;
    logic to_r;
    // cnt counts completed WAIT cycles; abort on the TIMEOUT_CYCLES-th one
    assign to          = state == WAIT && !core_done && cnt == CNT_W'(TIMEOUT_CYCLES - 1);
    assign timeout_err = state == RETURN && to_r;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt  <= '0;
            to_r <= 1'b0;
        end else begin
            cnt  <= (state == WAIT && !fin) ? cnt + 1'b1 : '0;
            to_r <= to;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign to             = 1'b0;
    assign timeout_err    = 1'b0;
`endif
endmodule

// File: tb/tb_fp_core_arbiter.sv
// tb_fp_core_arbiter: directed scoreboard bench for fp_core_arbiter with a behavioural core model
module tb_fp_core_arbiter;
    import fp_arb_pkg::*;

    logic clk = 1'b0, reset_n = 1'b0;
    logic req0_start = 1'b0, req1_start = 1'b0;
    logic [31:0] req0_dataa = '0, req0_datab = '0, req1_dataa = '0, req1_datab = '0;
    logic req0_done, req1_done, req0_busy, req1_busy, core_start, grant_id, timeout_err;
    logic [31:0] req0_result, req1_result, core_dataa, core_datab;
    logic core_done_m = 1'b0, spur_done = 1'b0;
    logic [31:0] core_result = '0;

    typedef struct {bit id; logic [31:0] res; bit to;} exp_t;
    typedef struct {bit id; logic [31:0] a; logic [31:0] b;} op_t;
    exp_t exp_q[$];
    op_t  op_q[$];
    exp_t e;
    op_t  o;
    int n_cmp = 0, n_bad = 0, cyc = 0, ldc = -100;
    int core_mode = 0, core_dly = 5;
    logic [31:0] ca, cb;

    fp_core_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .req0_start(req0_start), .req0_dataa(req0_dataa), .req0_datab(req0_datab),
        .req1_start(req1_start), .req1_dataa(req1_dataa), .req1_datab(req1_datab),
        .req0_done(req0_done), .req0_result(req0_result), .req0_busy(req0_busy),
        .req1_done(req1_done), .req1_result(req1_result), .req1_busy(req1_busy),
        .core_start(core_start), .core_dataa(core_dataa), .core_datab(core_datab),
        .core_done(core_done_m | spur_done), .core_result(core_result),
        .grant_id(grant_id), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, want);
        end
    endtask

    task automatic check_zero(input string name);
        check({name, "_ctl"}, {req0_done, req1_done, req0_busy, req1_busy, core_start, grant_id, timeout_err}, 0);
        check({name, "_res"}, {req0_result, req1_result}, 0);
        check({name, "_ops"}, {core_dataa, core_datab}, 0);
    endtask

    task automatic pulse(input bit s0, input logic [31:0] a0, b0, input bit s1, input logic [31:0] a1, b1);
        @(negedge clk);
        req0_start = s0;
        req1_start = s1;
        if (s0) begin req0_dataa = a0; req0_datab = b0; end
        if (s1) begin req1_dataa = a1; req1_datab = b1; end
        @(negedge clk);
        req0_start = 1'b0;
        req1_start = 1'b0;
    endtask

    task automatic want_op(input bit id, input logic [31:0] a, b, input bit keep, input logic [31:0] res, input bit to);
        op_q.push_back('{id, a, b});
        if (keep) exp_q.push_back('{id, res, to});
    endtask

    task automatic wait_idle(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            ok = exp_q.size() == 0 && op_q.size() == 0 && !req0_busy && !req1_busy;
        end
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: arbiter not idle within 300 cycles", name);
        end
        repeat (2) @(negedge clk);
    endtask

    // core model: checks issued operands, answers with a+b after core_dly cycles
    initial forever begin
        @(negedge clk);
        if (core_start) begin
            ca = core_dataa;
            cb = core_datab;
            if (op_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL core_start: unexpected issue of %h %h", ca, cb);
            end else begin
                o = op_q.pop_front();
                check("core_grant", grant_id, o.id);
                check("core_dataa", ca, o.a);
                check("core_datab", cb, o.b);
            end
            if (core_mode != 2) begin
                if (core_mode == 1) begin
                    core_done_m = 1'b1;
                    core_result = 32'hDEADBEEF;
                    @(negedge clk);
                    core_done_m = 1'b0;
                    repeat (core_dly - 2) @(negedge clk);
                end else begin
                    repeat (core_dly - 1) @(negedge clk);
                end
                core_done_m = 1'b1;
                core_result = ca + cb;
                ldc = cyc;
                @(negedge clk);
                core_done_m = 1'b0;
            end
        end
    end

    // monitor: every done pulse must match the head of the scoreboard
    initial forever begin
        @(negedge clk);
        if (req0_done || req1_done) begin
            if (req0_done && req1_done) begin
                n_cmp++;
                n_bad++;
                $display("FAIL done_both: both done pulses high together");
            end else if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL done_unexpected: req0_done=%b req1_done=%b with nothing outstanding", req0_done, req1_done);
            end else begin
                e = exp_q.pop_front();
                check("done_id", req1_done, e.id);
                check("result", e.id ? req1_result : req0_result, e.res);
                check("timeout_err", timeout_err, e.to);
                if (!e.to) check("done_latency", cyc, ldc + 1);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        check_zero("reset");
        reset_n = 1'b1;

        want_op(0, 32'h437F0000, 32'h43000000, 1, 32'h867F0000, 0);
        pulse(1, 32'h437F0000, 32'h43000000, 0, 0, 0);
        check("lat_cycle1", {core_start, req0_busy}, 2'b01);
        @(negedge clk);
        check("lat_cycle2", core_start, 1);
        wait_idle("single");

        @(negedge clk); reset_n = 1'b0;
        @(negedge clk); reset_n = 1'b1;
        want_op(0, 32'h3F800000, 32'h40000000, 1, 32'h7F800000, 0);
        want_op(1, 32'h40400000, 32'h40800000, 1, 32'h80C00000, 0);
        pulse(1, 32'h3F800000, 32'h40000000, 1, 32'h40400000, 32'h40800000);
        wait_idle("tie_after_reset");

        want_op(0, 32'h01000000, 32'h02000000, 1, 32'h03000000, 0);
        want_op(1, 32'h11111111, 32'h22222222, 1, 32'h33333333, 0);
        pulse(1, 32'h01000000, 32'h02000000, 1, 32'h11111111, 32'h22222222);
        repeat (2) @(negedge clk);
        pulse(0, 0, 0, 1, 32'hAAAAAAAA, 32'h55555555);
        check("busy_hold", req1_busy, 1);
        wait_idle("restart_ignored");

        @(negedge clk); spur_done = 1'b1;
        @(negedge clk); spur_done = 1'b0;
        check("spur_idle1", {core_start, req0_busy, req1_busy}, 0);
        @(negedge clk);
        check("spur_idle2", {core_start, req0_busy, req1_busy}, 0);
        core_mode = 1;
        want_op(0, 32'h00000001, 32'h00000002, 1, 32'h00000003, 0);
        pulse(1, 32'h00000001, 32'h00000002, 0, 0, 0);
        wait_idle("spur_issue");
        core_mode = 0;

        want_op(1, 32'h00000100, 32'h00000200, 1, 32'h00000300, 0);
        want_op(0, 32'h00000010, 32'h00000020, 1, 32'h00000030, 0);
        pulse(1, 32'h00000010, 32'h00000020, 1, 32'h00000100, 32'h00000200);
        wait_idle("tie_round_robin");

        want_op(0, 32'h00000005, 32'h00000006, 1, 32'h0000000B, 0);
        pulse(1, 32'h00000005, 32'h00000006, 0, 0, 0);
        begin
            bit seen = 1'b0;
            for (int i = 0; i < 40 && !seen; i++) begin
                @(negedge clk);
                seen = req0_done;
            end
            check("return_seen", seen, 1);
        end
        want_op(0, 32'h00000007, 32'h00000008, 1, 32'h0000000F, 0);
        req0_start = 1'b1;
        req0_dataa = 32'h00000007;
        req0_datab = 32'h00000008;
        @(negedge clk);
        req0_start = 1'b0;
        wait_idle("start_in_return");

        core_dly = 10;
        want_op(0, 32'h00001000, 32'h00002000, 0, 0, 0);
        pulse(1, 32'h00001000, 32'h00002000, 0, 0, 0);
        repeat (4) @(negedge clk);
        #2 reset_n = 1'b0;
        #1 check_zero("mid_reset");
        @(negedge clk); reset_n = 1'b1;
        repeat (15) @(negedge clk);
        check("after_reset", {req0_busy, req1_busy, core_start, req0_result}, 0);
        core_dly = 5;
        want_op(1, 32'h00000003, 32'h00000004, 1, 32'h00000007, 0);
        pulse(0, 0, 0, 1, 32'h00000003, 32'h00000004);
        wait_idle("post_reset");

`ifdef FP_ARB_TIMEOUT_EN
        core_mode = 2;
        want_op(0, 32'h00000009, 32'h00000009, 1, QNAN, 1);
        pulse(1, 32'h00000009, 32'h00000009, 0, 0, 0);
        wait_idle("timeout");
        core_mode = 0;
`endif

        check("exp_q_empty", exp_q.size(), 0);
        check("op_q_empty", op_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
